// File: rtl/dmem_pkg.sv
// dmem_pkg: shared store-buffer entry type and drain FSM encodings.
package dmem_pkg;
    // idx is sized for the widest usable AW; narrower word indices are zero-extended.
    localparam int IDX_W = 30;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } sb_entry_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: 2**AW x 32 word RAM, asynchronous read, synchronous write, contents not reset.
module dmem_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [2**AW];
    always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: M-stage data memory with an in-order store buffer draining into a slow-write RAM.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int AW     = 6,
    parameter int DEPTH  = 4,
    parameter int WR_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memwriteM,
    input  logic                     memreadM,
    input  logic [31:0]              addrM,
    input  logic [31:0]              writedataM,
    output logic [31:0]              readdataM,
    output logic                     stallM,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    logic [PW:0]    head_q, head_d, tail_q, tail_d, count, count_next;
    logic [0:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    sb_entry_t      buf_q [DEPTH];
    sb_entry_t      buf_d [DEPTH];
    logic [AW-1:0]  widx;
    logic [31:0]    ram_rdata;
    logic           full, empty, commit, enq, unused;
    assign widx   = addrM[AW+1:2];
    assign count  = tail_q - head_q;
    assign empty  = head_q == tail_q;
    assign full   = (head_q[PW] != tail_q[PW]) && (head_q[PW-1:0] == tail_q[PW-1:0]);
    assign commit = (state_q == S_WRITE) && (cnt_q == '0);
    assign stallM = memwriteM & full & ~commit;
    assign enq    = memwriteM & ~stallM;
    assign sb_count = count;
    assign busy   = !empty || (state_q == S_WRITE);
    assign unused = ^{memreadM, addrM[31:AW+2], addrM[1:0]};
    always_comb begin
        buf_d = buf_q;
        if (enq) buf_d[tail_q[PW-1:0]] = '{idx: IDX_W'(widx), data: writedataM};
        head_d = head_q + (PW+1)'(commit);
        tail_d = tail_q + (PW+1)'(enq);
        count_next = tail_d - head_d;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            state_d = empty ? S_IDLE : S_WRITE;
            cnt_d   = CW'(WR_LAT - 1);
        end else begin
            state_d = (commit && count_next == '0) ? S_IDLE : S_WRITE;
            cnt_d   = commit ? CW'(WR_LAT - 1) : cnt_q - CW'(1);
        end
    end
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        readdataM = ram_rdata;
        for (int i = 0; i < DEPTH; i++)
            if ((PW+1)'(i) < count && buf_q[head_q[PW-1:0] + PW'(i)].idx == IDX_W'(widx))
                readdataM = buf_q[head_q[PW-1:0] + PW'(i)].data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) buf_q <= buf_d;
    // A commit coinciding with reset is abandoned, not written.
    dmem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (commit & ~rst),
        .waddr (buf_q[head_q[PW-1:0]].idx[AW-1:0]),
        .wdata (buf_q[head_q[PW-1:0]].data),
        .raddr (widx),
        .rdata (ram_rdata)
    );
endmodule
